fft_output_serializer: RTL

//  Sits directly downstream of fft_top (radix-4 SDF). Captures the 4-lane output frame and

---
 rtl/fft_output_serializer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fft_output_serializer.sv
// Captures 4-lane radix-4 FFT output frames into a ping-pong buffer and streams one bin per cycle in natural order.
// Latency: out_valid rises 2 edges after the last beat is captured. Backpressure: out_ready low holds all outputs; beats for a full bank are dropped (sticky overflow).
// Optional FFT_OUT_SCALE_EN: outputs are divided by N with round-half-up.
module fft_output_serializer #(
  parameter int WIDTH          = 32,
  parameter int Num_of_samples = 16
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              input_en,
  input  logic [WIDTH-1:0]                  input_real_0,
  input  logic [WIDTH-1:0]                  input_real_1,
  input  logic [WIDTH-1:0]                  input_real_2,
  input  logic [WIDTH-1:0]                  input_real_3,
  input  logic [WIDTH-1:0]                  input_imag_0,
  input  logic [WIDTH-1:0]                  input_imag_1,
  input  logic [WIDTH-1:0]                  input_imag_2,
  input  logic [WIDTH-1:0]                  input_imag_3,
  input  logic                              out_ready,
  output logic                              out_valid,
  output logic [WIDTH-1:0]                  out_real,
  output logic [WIDTH-1:0]                  out_imag,
  output logic [$clog2(Num_of_samples)-1:0] out_index,
  output logic                              out_last,
  output logic                              overflow
);

  localparam int N    = Num_of_samples;
  localparam int LOGN = $clog2(N);
  localparam int Q    = N / 4;
  localparam int CW   = LOGN - 2;
  localparam int AW   = LOGN + 1;

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  logic [WIDTH-1:0] r_mem_re [0:2*N-1];
  logic [WIDTH-1:0] r_mem_im [0:2*N-1];

  logic [1:0]      r_full;
  logic            r_wr_bank;
  logic [CW-1:0]   r_wr_cnt;
  logic            r_set_pend;
  logic            r_set_bank;
  logic            r_rd_bank;
  logic [LOGN-1:0] r_rd_idx;
  state_t          r_state;

  logic [WIDTH-1:0] w_lane_re [4];
  logic [WIDTH-1:0] w_lane_im [4];
  logic             w_wr_acc;
  logic             w_wr_last;
  logic             w_rd_done;
  logic [LOGN-1:0]  w_rd_ptr;
  logic [AW-1:0]    w_rd_addr;
  logic [WIDTH-1:0] w_rd_re;
  logic [WIDTH-1:0] w_rd_im;

  assign w_lane_re[0] = input_real_0;
  assign w_lane_re[1] = input_real_1;
  assign w_lane_re[2] = input_real_2;
  assign w_lane_re[3] = input_real_3;
  assign w_lane_im[0] = input_imag_0;
  assign w_lane_im[1] = input_imag_1;
  assign w_lane_im[2] = input_imag_2;
  assign w_lane_im[3] = input_imag_3;

  function automatic logic [WIDTH-1:0] f_scale(input logic [WIDTH-1:0] x);
`ifdef FFT_OUT_SCALE_EN
    logic [WIDTH:0]        v;
    logic signed [WIDTH:0] s;
    v = {x[WIDTH-1], x} + ((WIDTH+1)'(1) << (LOGN - 1));
    s = $signed(v) >>> LOGN;
    return s[WIDTH-1:0];
`else
    return x;
`endif
  endfunction

  assign w_wr_acc  = input_en && !r_full[r_wr_bank];
  assign w_wr_last = (r_wr_cnt == CW'(Q - 1));
  assign w_rd_done = (r_state == S_STREAM) && out_ready && (r_rd_idx == LOGN'(N - 1));

  assign w_rd_ptr  = (r_state == S_IDLE) ? '0 : r_rd_idx + LOGN'(1);
  assign w_rd_addr = {r_rd_bank, w_rd_ptr};
  assign w_rd_re   = r_mem_re[w_rd_addr];
  assign w_rd_im   = r_mem_im[w_rd_addr];

  // Lane k of beat c lands at bin c + k*N/4, i.e. address {bank, k, c}.
  always_ff @(posedge clock) begin
    if (w_wr_acc) begin
      for (int k = 0; k < 4; k++) begin
        r_mem_re[{r_wr_bank, 2'(k), r_wr_cnt}] <= w_lane_re[k];
        r_mem_im[{r_wr_bank, 2'(k), r_wr_cnt}] <= w_lane_im[k];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_bank  <= 1'b0;
      r_wr_cnt   <= '0;
      r_set_pend <= 1'b0;
      r_set_bank <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      r_set_pend <= w_wr_acc && w_wr_last;
      if (w_wr_acc) begin
        if (w_wr_last) begin
          r_wr_cnt   <= '0;
          r_wr_bank  <= ~r_wr_bank;
          r_set_bank <= r_wr_bank;
        end else begin
          r_wr_cnt <= r_wr_cnt + CW'(1);
        end
      end
      if (input_en && r_full[r_wr_bank]) overflow <= 1'b1;
    end
  end

  // The full flag is set one cycle after the last beat; a bank being set can never be the one draining.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_full <= '0;
    end else begin
      if (r_set_pend) r_full[r_set_bank] <= 1'b1;
      if (w_rd_done)  r_full[r_rd_bank]  <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_rd_bank <= 1'b0;
      r_rd_idx  <= '0;
      out_valid <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_full[r_rd_bank]) begin
            out_real  <= f_scale(w_rd_re);
            out_imag  <= f_scale(w_rd_im);
            out_index <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b1;
            r_rd_idx  <= '0;
            r_state   <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (out_ready) begin
            if (r_rd_idx == LOGN'(N - 1)) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              r_rd_idx  <= '0;
              r_rd_bank <= ~r_rd_bank;
              r_state   <= S_IDLE;
            end else begin
              out_real  <= f_scale(w_rd_re);
              out_imag  <= f_scale(w_rd_im);
              out_index <= w_rd_ptr;
              out_last  <= (w_rd_ptr == LOGN'(N - 1));
              r_rd_idx  <= w_rd_ptr;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
